term_ctrl: RTL

- Terminal controller that owns VRAM port A of the text engine (60x17 cells, address {5'row, 6'col}, 64-cell row stride).
- Accepts a byte stream over a valid/ready handshake, typically from the UART receiver.
- Writes printable characters at the cursor and interprets control codes (CR, LF, BS, FF).
- Sequences full-screen scroll and clear; when idle, parks the VRAM address on the cursor cell so the cursor overlay tracks it.

---
 rtl/term_pkg.sv | 29 ++
 rtl/term_blit.sv | 133 +++++++++++++
 rtl/term_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
// Shared control codes, controller state encoding and VRAM address packing
// for the terminal controller and its blitter.
package term_pkg;

    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_TAB = 8'h09;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_FF  = 8'h0C;
    localparam logic [7:0] CHR_CR  = 8'h0D;

    localparam int ROW_W  = 5;
    localparam int COL_W  = 6;
    localparam int ADDR_W = ROW_W + COL_W;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCROLL_RD,
        SCROLL_WR,
        CLR_LINE,
        CLR_ALL
    } term_state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/term_blit.sv
// Full-screen sweeper: scroll (read/write alternation per cell, then blank last row)
// and clears, one VRAM access per cycle; start is a pulse, done pulses on the final cell.
module term_blit
    import term_pkg::*;
#(
    parameter int          COLS  = 60,
    parameter int          ROWS  = 17,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  term_state_t       op_i,
    input  logic [7:0]        vram_dout_i,
    output logic              done_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        din_o,
    output logic              ce_o,
    output logic              we_o
);

    localparam logic [COL_W-1:0] COL_LAST = 6'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = 5'(ROWS - 1);

    term_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLR_ALL;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done_o  = 1'b0;
        addr_o  = pack_addr(row_q, col_q);
        din_o   = BLANK;
        ce_o    = (state_q != IDLE);
        we_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    col_d = '0;
                    case (op_i)
                        SCROLL_RD: begin
                            // A one-row screen has nothing to move up, only a line to blank.
                            if (ROWS > 1) begin
                                state_d = SCROLL_RD;
                                row_d   = 5'd1;
                            end else begin
                                state_d = CLR_LINE;
                                row_d   = ROW_LAST;
                            end
                        end
                        CLR_LINE: begin
                            state_d = CLR_LINE;
                            row_d   = ROW_LAST;
                        end
                        default: begin
                            state_d = CLR_ALL;
                            row_d   = '0;
                        end
                    endcase
                end
            end

            SCROLL_RD: begin
                state_d = SCROLL_WR;
            end

            SCROLL_WR: begin
                // Read data from the previous cycle lands one row higher.
                addr_o  = pack_addr(row_q - 5'd1, col_q);
                din_o   = vram_dout_i;
                we_o    = 1'b1;
                state_d = SCROLL_RD;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = CLR_LINE;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end

            CLR_LINE: begin
                we_o = 1'b1;
                if (col_q == COL_LAST) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 6'd1;
                end
            end

            CLR_ALL: begin
                we_o = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller on VRAM port A: cursor, byte handshake (1 printable per 2 cycles,
// o_ready low during scroll/clear) and control-code decode; TERM_TAB_EN enables TAB stops.
module term_ctrl
    import term_pkg::*;
#(
    parameter int         COLS  = 60,
    parameter int         ROWS  = 17,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    input  logic [7:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic        o_cursor_e,
    output logic        o_busy
);

    localparam logic [COL_W-1:0] COL_LAST = 6'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = 5'(ROWS - 1);

    // While the blitter runs, state_q holds the operation it was started with.
    term_state_t      state_q, state_d;
    logic [ROW_W-1:0] cur_row_q, cur_row_d;
    logic [COL_W-1:0] cur_col_q, cur_col_d;
    logic [7:0]       data_q, data_d;

    logic              blit_start;
    term_state_t       blit_op;
    logic              blit_done;
    logic [ADDR_W-1:0] blit_addr;
    logic [7:0]        blit_din;
    logic              blit_ce;
    logic              blit_we;

`ifdef TERM_TAB_EN
    logic [COL_W:0]   tab_sum;
    logic [COL_W-1:0] tab_col;
    assign tab_sum = {1'b0, cur_col_q | 6'd7} + 7'd1;
    assign tab_col = (tab_sum > 7'(COLS - 1)) ? COL_LAST : tab_sum[COL_W-1:0];
`endif

    term_blit #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (BLANK)
    ) u_blit (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .start_i     (blit_start),
        .op_i        (blit_op),
        .vram_dout_i (i_vram_dout),
        .done_o      (blit_done),
        .addr_o      (blit_addr),
        .din_o       (blit_din),
        .ce_o        (blit_ce),
        .we_o        (blit_we)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CLR_ALL;
            cur_row_q <= '0;
            cur_col_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        data_d      = data_q;
        blit_start  = 1'b0;
        blit_op     = CLR_ALL;
        o_ready     = 1'b0;
        o_cursor_e  = 1'b0;
        o_vram_ce   = 1'b0;
        o_vram_wre  = 1'b0;
        o_vram_din  = '0;
        o_vram_addr = pack_addr(cur_row_q, cur_col_q);
        o_busy      = !(state_q == IDLE || state_q == PUT);

        case (state_q)
            IDLE: begin
                o_ready    = !i_rst;
                o_cursor_e = !i_rst;
                if (i_valid && !i_rst) begin
                    if (i_data >= 8'h20) begin
                        data_d  = i_data;
                        state_d = PUT;
                    end else begin
                        case (i_data)
                            CHR_CR: cur_col_d = '0;
                            CHR_BS: begin
                                if (cur_col_q != '0) cur_col_d = cur_col_q - 6'd1;
                            end
                            CHR_LF: begin
                                if (cur_row_q != ROW_LAST) begin
                                    cur_row_d = cur_row_q + 5'd1;
                                end else begin
                                    blit_start = 1'b1;
                                    blit_op    = SCROLL_RD;
                                    state_d    = SCROLL_RD;
                                end
                            end
                            CHR_FF: begin
                                cur_row_d  = '0;
                                cur_col_d  = '0;
                                blit_start = 1'b1;
                                blit_op    = CLR_ALL;
                                state_d    = CLR_ALL;
                            end
`ifdef TERM_TAB_EN
                            CHR_TAB: cur_col_d = tab_col;
`endif
                            default: ;
                        endcase
                    end
                end
            end

            PUT: begin
                o_cursor_e = !i_rst;
                o_vram_ce  = !i_rst;
                o_vram_wre = !i_rst;
                o_vram_din = i_rst ? 8'h00 : data_q;
                state_d    = IDLE;
                if (cur_col_q == COL_LAST) begin
                    cur_col_d = '0;
                    if (cur_row_q != ROW_LAST) begin
                        cur_row_d = cur_row_q + 5'd1;
                    end else begin
                        blit_start = 1'b1;
                        blit_op    = SCROLL_RD;
                        state_d    = SCROLL_RD;
                    end
                end else begin
                    cur_col_d = cur_col_q + 6'd1;
                end
            end

            default: begin
                o_vram_addr = blit_addr;
                o_vram_din  = i_rst ? 8'h00 : blit_din;
                o_vram_ce   = blit_ce && !i_rst;
                o_vram_wre  = blit_we && !i_rst;
                if (blit_done) state_d = IDLE;
            end
        endcase
    end

endmodule
